// File: rtl/hwpe_ctrl_vfpu_package.sv
// ---------------------------------------------------------------------------
// hwpe_ctrl_vfpu_package: shared types for the VFPU normalization scheduler. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hwpe_ctrl_vfpu_package;

    localparam int unsigned VFPU_NUM_LANES        = 4;
    localparam int unsigned FP_EXP_WIDTH          = 8;
    localparam int unsigned FP_MANT_WIDTH         = 23;
    // Pre-normalization operands carry two guard exponent bits and a full product mantissa
    localparam int unsigned FP_EXP_PRENORM_WIDTH  = FP_EXP_WIDTH + 2;
    localparam int unsigned FP_MANT_PRENORM_WIDTH = 2 * (FP_MANT_WIDTH + 1);

    typedef enum logic [3:0] {
        VFPU_OP_ADD = 4'd0,
        VFPU_OP_SUB = 4'd1,
        VFPU_OP_MUL = 4'd2,
        VFPU_OP_FMA = 4'd3,
        VFPU_OP_DIV = 4'd4
    } vfpu_op_e;

    typedef enum logic [2:0] {
        VFPU_RM_RNE = 3'd0,
        VFPU_RM_RTZ = 3'd1,
        VFPU_RM_RDN = 3'd2,
        VFPU_RM_RUP = 3'd3,
        VFPU_RM_RMM = 3'd4
    } vfpu_rm_e;

    typedef struct packed {
        vfpu_op_e op;
        vfpu_rm_e rm;
    } ctrl_vfpu_t;

    typedef struct packed {
        logic invalid;
        logic div_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } flags_vfpu_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } vfpu_norm_sched_state_t;

endpackage

`default_nettype wire

// File: rtl/vfpu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// vfpu_rr_arbiter: round-robin one-hot grant, pointer advances past the winner on enable. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vfpu_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);

    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;
    int unsigned      w_sum;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        w_sum     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_sum = 32'(ptr_q) + i;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_cand = IDX_W'(w_sum);
            if (!w_found && req_i[w_cand]) begin
                gnt_o[w_cand] = 1'b1;
                gnt_idx_o     = w_cand;
                w_found       = 1'b1;
            end
        end
    end

    assign ptr_d = (gnt_idx_o == C_LAST) ? '0 : gnt_idx_o + IDX_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (clear_i) begin
            ptr_q <= '0;
        end else if (en_i && w_found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vfpu_norm_sched.sv
// ---------------------------------------------------------------------------
// vfpu_norm_sched: shares one normalization/rounding unit among NUM_LANES lanes. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vfpu_norm_sched
    import hwpe_ctrl_vfpu_package::*;
#(
    parameter int unsigned NUM_LANES = VFPU_NUM_LANES
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        clear_i,
    input  ctrl_vfpu_t                                  ctrl_vfpu_i,
    input  logic [NUM_LANES-1:0]                        req_valid_i,
    output logic [NUM_LANES-1:0]                        req_ready_o,
    input  logic [NUM_LANES-1:0]                        req_sign_i,
    input  logic [NUM_LANES*FP_EXP_PRENORM_WIDTH-1:0]   req_exp_i,
    input  logic [NUM_LANES*FP_MANT_PRENORM_WIDTH-1:0]  req_mant_i,
    output logic                                        norm_sign_o,
    output logic [FP_EXP_PRENORM_WIDTH-1:0]             norm_exp_o,
    output logic [FP_MANT_PRENORM_WIDTH-1:0]            norm_mant_o,
    output logic                                        norm_start_o,
    output ctrl_vfpu_t                                  ctrl_vfpu_o,
    input  logic                                        norm_sign_i,
    input  logic [FP_EXP_WIDTH-1:0]                     norm_exp_i,
    input  logic [FP_MANT_WIDTH:0]                      norm_mant_i,
    input  flags_vfpu_t                                 norm_flags_i,
    input  logic                                        norm_done_i,
    output logic [NUM_LANES-1:0]                        res_valid_o,
    input  logic [NUM_LANES-1:0]                        res_ready_i,
    output logic [NUM_LANES-1:0]                        res_sign_o,
    output logic [NUM_LANES*FP_EXP_WIDTH-1:0]           res_exp_o,
    output logic [NUM_LANES*(FP_MANT_WIDTH+1)-1:0]      res_mant_o,
    output logic [NUM_LANES*$bits(flags_vfpu_t)-1:0]    res_flags_o,
    output flags_vfpu_t                                 flags_acc_o,
    output logic                                        busy_o
);

    localparam int unsigned IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned EPW   = FP_EXP_PRENORM_WIDTH;
    localparam int unsigned MPW   = FP_MANT_PRENORM_WIDTH;
    localparam int unsigned EW    = FP_EXP_WIDTH;
    localparam int unsigned MW    = FP_MANT_WIDTH + 1;
    localparam int unsigned FW    = $bits(flags_vfpu_t);

    vfpu_norm_sched_state_t state_q, state_d;
    logic [IDX_W-1:0]       lane_q, lane_d;
    logic                   op_sign_q, op_sign_d;
    logic [EPW-1:0]         op_exp_q, op_exp_d;
    logic [MPW-1:0]         op_mant_q, op_mant_d;
    logic [NUM_LANES-1:0]   res_valid_q, res_valid_d;
    flags_vfpu_t            flags_acc_q, flags_acc_d;

    logic                   res_sign_q  [NUM_LANES];
    logic [EW-1:0]          res_exp_q   [NUM_LANES];
    logic [MW-1:0]          res_mant_q  [NUM_LANES];
    flags_vfpu_t            res_flags_q [NUM_LANES];

    logic [EPW-1:0]         w_req_exp   [NUM_LANES];
    logic [MPW-1:0]         w_req_mant  [NUM_LANES];
    logic [NUM_LANES-1:0]   w_eligible;
    logic [NUM_LANES-1:0]   w_gnt;
    logic [IDX_W-1:0]       w_gnt_idx;
    logic                   w_grant_en;
    logic                   w_capture;
    logic                   w_start;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign w_req_exp[l]                 = req_exp_i[l*EPW +: EPW];
        assign w_req_mant[l]                = req_mant_i[l*MPW +: MPW];
        assign res_sign_o[l]                = res_sign_q[l];
        assign res_exp_o[l*EW +: EW]        = res_exp_q[l];
        assign res_mant_o[l*MW +: MW]       = res_mant_q[l];
        assign res_flags_o[l*FW +: FW]      = res_flags_q[l];
    end

    // A lane still holding an undrained result cannot take a new job
    assign w_eligible = req_valid_i & ~res_valid_q;

    vfpu_rr_arbiter #(
        .NUM_REQ (NUM_LANES)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .req_i     (w_eligible),
        .en_i      (w_grant_en),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx)
    );

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        op_sign_d   = op_sign_q;
        op_exp_d    = op_exp_q;
        op_mant_d   = op_mant_q;
        res_valid_d = res_valid_q & ~res_ready_i;
        flags_acc_d = flags_acc_q;
        w_grant_en  = 1'b0;
        w_capture   = 1'b0;
        w_start     = 1'b0;

        case (state_q)
            IDLE: begin
                w_grant_en = rst_ni & ~clear_i;
                if (w_grant_en && (|w_gnt)) begin
                    lane_d    = w_gnt_idx;
                    op_sign_d = req_sign_i[w_gnt_idx];
                    op_exp_d  = w_req_exp[w_gnt_idx];
                    op_mant_d = w_req_mant[w_gnt_idx];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                w_start = 1'b1;
                if (norm_done_i) begin
                    w_capture = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                w_start = 1'b1;
                if (norm_done_i) begin
                    w_capture = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_capture) begin
            res_valid_d[lane_q] = 1'b1;
            flags_acc_d         = flags_acc_q | norm_flags_i;
        end

        if (clear_i) begin
            state_d     = IDLE;
            res_valid_d = '0;
            flags_acc_d = '0;
            w_capture   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            op_sign_q   <= 1'b0;
            op_exp_q    <= '0;
            op_mant_q   <= '0;
            res_valid_q <= '0;
            flags_acc_q <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            op_sign_q   <= op_sign_d;
            op_exp_q    <= op_exp_d;
            op_mant_q   <= op_mant_d;
            res_valid_q <= res_valid_d;
            flags_acc_q <= flags_acc_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                res_sign_q[l]  <= 1'b0;
                res_exp_q[l]   <= '0;
                res_mant_q[l]  <= '0;
                res_flags_q[l] <= '0;
            end
        end else if (w_capture) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (lane_q == IDX_W'(l)) begin
                    res_sign_q[l]  <= norm_sign_i;
                    res_exp_q[l]   <= norm_exp_i;
                    res_mant_q[l]  <= norm_mant_i;
                    res_flags_q[l] <= norm_flags_i;
                end
            end
        end
    end

    assign req_ready_o  = w_grant_en ? w_gnt : '0;
    assign norm_sign_o  = op_sign_q;
    assign norm_exp_o   = op_exp_q;
    assign norm_mant_o  = op_mant_q;
    assign norm_start_o = w_start;
    assign ctrl_vfpu_o  = ctrl_vfpu_i;
    assign res_valid_o  = res_valid_q;
    assign flags_acc_o  = flags_acc_q;
    assign busy_o       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_vfpu_norm_sched.sv
// ---------------------------------------------------------------------------
// tb_vfpu_norm_sched: directed vector table plus hand sequences for the scheduler. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vfpu_norm_sched;
    import hwpe_ctrl_vfpu_package::*;

    localparam int NL  = 4;
    localparam int EPW = FP_EXP_PRENORM_WIDTH;
    localparam int MPW = FP_MANT_PRENORM_WIDTH;
    localparam int EW  = FP_EXP_WIDTH;
    localparam int MW  = FP_MANT_WIDTH + 1;
    localparam int FW  = $bits(flags_vfpu_t);

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 clear_i;
    ctrl_vfpu_t           ctrl_vfpu_i;
    logic [NL-1:0]        req_valid_i;
    logic [NL-1:0]        req_ready_o;
    logic [NL-1:0]        req_sign_i;
    logic [NL*EPW-1:0]    req_exp_i;
    logic [NL*MPW-1:0]    req_mant_i;
    logic                 norm_sign_o;
    logic [EPW-1:0]       norm_exp_o;
    logic [MPW-1:0]       norm_mant_o;
    logic                 norm_start_o;
    ctrl_vfpu_t           ctrl_vfpu_o;
    logic                 norm_sign_i;
    logic [EW-1:0]        norm_exp_i;
    logic [MW-1:0]        norm_mant_i;
    flags_vfpu_t          norm_flags_i;
    logic                 norm_done_i;
    logic [NL-1:0]        res_valid_o;
    logic [NL-1:0]        res_ready_i;
    logic [NL-1:0]        res_sign_o;
    logic [NL*EW-1:0]     res_exp_o;
    logic [NL*MW-1:0]     res_mant_o;
    logic [NL*FW-1:0]     res_flags_o;
    flags_vfpu_t          flags_acc_o;
    logic                 busy_o;

    vfpu_norm_sched #(.NUM_LANES(NL)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .ctrl_vfpu_i(ctrl_vfpu_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_sign_i(req_sign_i),
        .req_exp_i(req_exp_i), .req_mant_i(req_mant_i), .norm_sign_o(norm_sign_o),
        .norm_exp_o(norm_exp_o), .norm_mant_o(norm_mant_o), .norm_start_o(norm_start_o),
        .ctrl_vfpu_o(ctrl_vfpu_o), .norm_sign_i(norm_sign_i), .norm_exp_i(norm_exp_i),
        .norm_mant_i(norm_mant_i), .norm_flags_i(norm_flags_i), .norm_done_i(norm_done_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_sign_o(res_sign_o),
        .res_exp_o(res_exp_o), .res_mant_o(res_mant_o), .res_flags_o(res_flags_o),
        .flags_acc_o(flags_acc_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]     lane;
        logic           sign;
        logic [EPW-1:0] exp;
        logic [MPW-1:0] mant;
        logic           r_sign;
        logic [EW-1:0]  r_exp;
        logic [MW-1:0]  r_mant;
        logic [FW-1:0]  r_flags;
        logic [NL-1:0]  ready;
    } vec_t;

    vec_t          tbl [4];
    vec_t          v;
    logic [FW-1:0] acc;
    logic [NL-1:0] exp_a [10];
    logic [NL-1:0] exp_b [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic neg();
        @(negedge clk_i);
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
    endtask

    // Entered one step after a rising edge with the FSM idle; returns the same way
    task automatic run_job(input vec_t j);
        req_valid_i                     = '0;
        req_valid_i[j.lane]             = 1'b1;
        req_sign_i[j.lane]              = j.sign;
        req_exp_i                       = '0;
        req_exp_i[j.lane*EPW +: EPW]    = j.exp;
        req_mant_i                      = '0;
        req_mant_i[j.lane*MPW +: MPW]   = j.mant;
        norm_sign_i                     = j.r_sign;
        norm_exp_i                      = j.r_exp;
        norm_mant_i                     = j.r_mant;
        norm_flags_i                    = j.r_flags;
        norm_done_i                     = 1'b1;
        neg();
        chk("job_grant", 64'(req_ready_o), 64'(j.ready));
        chk("job_busy_idle", 64'(busy_o), 64'd0);
        cyc();
        req_valid_i = '0;
        neg();
        chk("job_start", 64'(norm_start_o), 64'd1);
        chk("job_op_sign", 64'(norm_sign_o), 64'(j.sign));
        chk("job_op_exp", 64'(norm_exp_o), 64'(j.exp));
        chk("job_op_mant", 64'(norm_mant_o), 64'(j.mant));
        chk("job_no_res_yet", 64'(res_valid_o), 64'd0);
        cyc();
        neg();
        chk("job_res_valid", 64'(res_valid_o), 64'(j.ready));
        chk("job_res_sign", 64'(res_sign_o[j.lane]), 64'(j.r_sign));
        chk("job_res_exp", 64'(res_exp_o[j.lane*EW +: EW]), 64'(j.r_exp));
        chk("job_res_mant", 64'(res_mant_o[j.lane*MW +: MW]), 64'(j.r_mant));
        chk("job_res_flags", 64'(res_flags_o[j.lane*FW +: FW]), 64'(j.r_flags));
        chk("job_start_once", 64'(norm_start_o), 64'd0);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'd2, 1'b0, 10'd10,   48'h0000_0012_3456, 1'b0, 8'h0A, 24'h800001, 5'b00000, 4'b0100};
        tbl[1] = '{2'd0, 1'b1, 10'h3FF,  48'hFFFF_FFFF_FFFF, 1'b1, 8'hFF, 24'hFFFFFF, 5'b00100, 4'b0001};
        tbl[2] = '{2'd3, 1'b0, 10'h000,  48'h0000_0000_0000, 1'b0, 8'h00, 24'h000000, 5'b01000, 4'b1000};
        tbl[3] = '{2'd1, 1'b1, 10'h155,  48'hA5A5_0000_5A5A, 1'b0, 8'h7F, 24'hC00000, 5'b00001, 4'b0010};
        exp_a  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        exp_b  = '{4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000,
                   4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010};

        rst_ni       = 1'b0;
        clear_i      = 1'b0;
        ctrl_vfpu_i  = '{op: VFPU_OP_FMA, rm: VFPU_RM_RUP};
        req_valid_i  = '1;
        req_sign_i   = '0;
        req_exp_i    = '0;
        req_mant_i   = '0;
        norm_sign_i  = 1'b0;
        norm_exp_i   = '0;
        norm_mant_i  = '0;
        norm_flags_i = '0;
        norm_done_i  = 1'b1;
        res_ready_i  = '1;

        // Reset values, with requests pending so the ready gating is exercised
        repeat (2) neg();
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_res_valid", 64'(res_valid_o), 64'd0);
        chk("rst_start", 64'(norm_start_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_flags_acc", 64'(flags_acc_o), 64'd0);
        chk("rst_norm_exp", 64'(norm_exp_o), 64'd0);
        chk("ctrl_forward", 64'(ctrl_vfpu_o), 64'({VFPU_OP_FMA, VFPU_RM_RUP}));
        cyc();
        req_valid_i = '0;
        rst_ni      = 1'b1;
        cyc();

        // Vector table: isolated jobs, done tied high
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            run_job(tbl[i]);
            acc = acc | tbl[i].r_flags;
        end
        neg();
        chk("tbl_flags_acc", 64'(flags_acc_o), 64'(acc));
        cyc();

        // All lanes requesting continuously
        pulse_clear();
        norm_done_i = 1'b1;
        req_valid_i = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            neg();
            chk("rr_all_grant", 64'(req_ready_o), 64'(exp_a[i]));
            chk("rr_all_onehot", 64'($countones(req_ready_o) <= 1), 64'd1);
            cyc();
        end
        req_valid_i = '0;
        repeat (3) cyc();

        // Lane 1 holds its result while re-requesting
        pulse_clear();
        res_ready_i = 4'b1101;
        req_valid_i = 4'b0010;
        norm_exp_i  = 8'h11;
        neg();
        chk("hold_first_grant", 64'(req_ready_o), 64'b0010);
        cyc();
        req_valid_i = '0;
        cyc();
        req_valid_i = 4'b1111;
        norm_exp_i  = 8'h22;
        for (int i = 0; i < 13; i++) begin
            if (i == 7) res_ready_i = 4'b1111;
            neg();
            chk("hold_grant", 64'(req_ready_o), 64'(exp_b[i]));
            chk("hold_lane1_valid", 64'(res_valid_o[1]), 64'(i <= 7));
            if (i <= 7) chk("hold_lane1_exp", 64'(res_exp_o[1*EW +: EW]), 64'h11);
            cyc();
        end
        req_valid_i = '0;
        repeat (3) cyc();

        // Shared unit answers three cycles after the start strobe
        req_valid_i = 4'b0001;
        norm_done_i = 1'b0;
        norm_exp_i  = 8'h33;
        neg();
        chk("wait_grant", 64'(req_ready_o), 64'b0001);
        cyc();
        req_valid_i = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("wait_start", 64'(norm_start_o), 64'd1);
            chk("wait_busy", 64'(busy_o), 64'd1);
            chk("wait_no_ready", 64'(req_ready_o), 64'd0);
            chk("wait_no_res", 64'(res_valid_o), 64'd0);
            cyc();
        end
        norm_done_i = 1'b1;
        norm_exp_i  = 8'h5A;
        neg();
        chk("wait_done_start", 64'(norm_start_o), 64'd1);
        chk("wait_done_no_res", 64'(res_valid_o), 64'd0);
        cyc();
        neg();
        chk("wait_res_valid", 64'(res_valid_o), 64'b0001);
        chk("wait_res_exp", 64'(res_exp_o[0 +: EW]), 64'h5A);
        chk("wait_busy_after", 64'(busy_o), 64'd0);
        chk("wait_next_grant", 64'(req_ready_o), 64'b1000);
        cyc();
        req_valid_i = '0;
        repeat (3) cyc();

        // Sticky flags and their clear
        pulse_clear();
        v = '{2'd0, 1'b0, 10'd1, 48'd1, 1'b0, 8'h01, 24'h000001, 5'b00100, 4'b0001};
        run_job(v);
        v = '{2'd1, 1'b1, 10'd2, 48'd2, 1'b1, 8'h02, 24'h000002, 5'b00001, 4'b0010};
        run_job(v);
        neg();
        chk("flags_both", 64'(flags_acc_o), 64'b00101);
        cyc();
        pulse_clear();
        neg();
        chk("flags_cleared", 64'(flags_acc_o), 64'd0);
        cyc();

        // Clear while waiting drops the job and resets the pointer
        v = '{2'd2, 1'b0, 10'd7, 48'd7, 1'b0, 8'h07, 24'h000007, 5'b00000, 4'b0100};
        run_job(v);
        req_valid_i = 4'b0010;
        norm_done_i = 1'b0;
        neg();
        chk("clr_grant", 64'(req_ready_o), 64'b0010);
        cyc();
        req_valid_i = '0;
        cyc();
        clear_i = 1'b1;
        neg();
        chk("clr_in_wait_busy", 64'(busy_o), 64'd1);
        cyc();
        clear_i     = 1'b0;
        req_valid_i = 4'b1111;
        neg();
        chk("clr_idle", 64'(busy_o), 64'd0);
        chk("clr_start_low", 64'(norm_start_o), 64'd0);
        chk("clr_no_res", 64'(res_valid_o), 64'd0);
        chk("clr_grant_lane0", 64'(req_ready_o), 64'b0001);
        cyc();
        req_valid_i = '0;
        norm_done_i = 1'b1;
        neg();
        chk("clr_job_no_res", 64'(res_valid_o), 64'd0);
        cyc();
        neg();
        chk("clr_job_res", 64'(res_valid_o), 64'b0001);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vfpu_norm_sched.md
VFPU_NORM_SCHED -- requirements
Module: vfpu_norm_sched

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, the number of lanes sharing one normalization/rounding unit (range 2..8).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port clear_i, input, 1, synchronous clear.
REQ-005 SHALL have port ctrl_vfpu_i, input, ctrl_vfpu_t, the operation and rounding mode; forwarded unchanged to ctrl_vfpu_o.
REQ-006 SHALL have port req_valid_i, input, NUM_LANES, per-lane request valid.
REQ-007 SHALL have port req_ready_o, output, NUM_LANES, per-lane request accept (one-hot or zero).
REQ-008 SHALL have port req_sign_i, input, NUM_LANES, per-lane pre-normalization sign.
REQ-009 SHALL have port req_exp_i, input, NUM_LANES*FP_EXP_PRENORM_WIDTH, per-lane pre-normalization exponents.
REQ-010 SHALL have port req_mant_i, input, NUM_LANES*FP_MANT_PRENORM_WIDTH, per-lane pre-normalization mantissas.
REQ-011 SHALL have ports norm_sign_o/norm_exp_o/norm_mant_o, output, 1/FP_EXP_PRENORM_WIDTH/FP_MANT_PRENORM_WIDTH, the registered operand driven to the shared unit.
REQ-012 SHALL have port norm_start_o, output, 1, the operand-ready strobe to the shared unit.
REQ-013 SHALL have port ctrl_vfpu_o, output, ctrl_vfpu_t, the control word to the shared unit.
REQ-014 SHALL have ports norm_sign_i/norm_exp_i/norm_mant_i, input, 1/FP_EXP_WIDTH/FP_MANT_WIDTH+1, the result from the shared unit.
REQ-015 SHALL have ports norm_flags_i (input, flags_vfpu_t) and norm_done_i (input, 1), the shared unit's flags and done.
REQ-016 SHALL have ports res_valid_o (output, NUM_LANES) and res_ready_i (input, NUM_LANES), per-lane result handshake.
REQ-017 SHALL have ports res_sign_o/res_exp_o/res_mant_o/res_flags_o, outputs, per-lane packed results and flags.
REQ-018 SHALL have port flags_acc_o, output, flags_vfpu_t, sticky OR of all job flags since reset or clear.
REQ-019 SHALL have port busy_o, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, with at most one job in flight.
REQ-021 In IDLE, a lane SHALL be eligible iff req_valid_i[l]=1 and res_valid_o[l]=0.
REQ-022 In IDLE, the grant SHALL be round-robin among eligible lanes, starting at the lane after the last granted one; after reset the priority order starts at lane 0.
REQ-023 In IDLE with a grant, req_ready_o SHALL be asserted for the granted lane only in that cycle, the lane operand and index SHALL be registered, and the FSM SHALL go to ISSUE.
REQ-024 In ISSUE, norm_start_o SHALL be high for exactly one cycle; if norm_done_i=1 the result SHALL be captured and the FSM SHALL go to IDLE, otherwise the FSM SHALL go to WAIT.
REQ-025 In WAIT, norm_start_o SHALL be held high until norm_done_i=1, then the result SHALL be captured and the FSM SHALL go to IDLE.
REQ-026 Latency: with norm_done_i combinational, res_valid_o[l] SHALL rise 2 cycles after the request handshake.
REQ-027 Throughput SHALL be 1 job per 2 cycles.
REQ-028 On capture, the lane result registers SHALL be loaded and res_valid_o[l] set, and flags_acc_o SHALL be ORed with norm_flags_i.
REQ-029 res_valid_o[l] SHALL clear on res_valid_o[l]&res_ready_i[l]; result data SHALL stay stable while valid and not ready.
REQ-030 A lane that drains its result in a cycle SHALL NOT be eligible until the following cycle.
REQ-031 clear_i SHALL have priority over all events: FSM to IDLE, in-flight job dropped, res_valid_o and flags_acc_o cleared, round-robin pointer reset to lane 0.

Reset
REQ-032 While rst_ni=0: FSM in IDLE; req_ready_o, res_valid_o, norm_start_o, busy_o and flags_acc_o all 0; operand and result registers 0; round-robin pointer at lane 0.

Structure
REQ-033 State enum vfpu_norm_sched_state_t and NUM_LANES default constant SHALL be placed in hwpe_ctrl_vfpu_package, alongside ctrl_vfpu_t and flags_vfpu_t.
REQ-034 The round-robin grant SHALL be a sub-module, vfpu_rr_arbiter (req, enable, grant one-hot, pointer update on enable).

Verification
REQ-035 Single job: lane 2 valid, exp=10, done tied high -> req_ready_o=4'b0100 at t, norm_start_o at t+1, res_valid_o[2] at t+2.
REQ-036 All four lanes valid continuously -> grants in order 0,1,2,3,0; exactly one req_ready_o bit high per grant cycle.
REQ-037 Lane 1 result held with res_ready_i[1]=0 while lane 1 requests again -> lane 1 skipped and lanes 0,2,3 served, until lane 1 drains.
REQ-038 norm_done_i delayed 3 cycles -> FSM remains in WAIT with norm_start_o high and busy_o=1; result captured on the done cycle.
REQ-039 One job with overflow=1, then one with inexact=1 -> flags_acc_o shows both bits; after clear_i both read 0.
REQ-040 clear_i asserted in WAIT -> no res_valid_o rises, FSM is in IDLE next cycle, and the next grant goes to lane 0.
